// File: rtl/m_update_blocks_pkg.sv
// Shared definitions for the block-grid update logic.
//   - Screen and grid geometry (pixels, cells, cell size as a shift).
//   - Number of cells in the blocks RAM.
//   - FSM state encoding for m_update_blocks.
//   - Saturating decrement helper for the remaining-blocks counter.
package m_update_blocks_pkg;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int GRID_W     = 20;
  localparam int GRID_H     = 15;
  localparam int CELL_SHIFT = 3;
  localparam int NUM_CELLS  = 300;
  localparam int ADDR_W     = 9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RD_CHK  = 3'd4,
    S_WR_CLR  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  // The block counter must never wrap below zero.
  function automatic logic [ADDR_W-1:0] sat_dec(input logic [ADDR_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

endpackage

// File: rtl/m_update_blocks_cell_index.sv
// m_cell_index: combinational pixel-to-cell conversion.
//   i_x     : pixel x (8 bits)
//   i_y     : pixel y (7 bits)
//   o_addr  : cell address (y>>CELL_SHIFT)*GRID_W + (x>>CELL_SHIFT), 9 bits
//   o_valid : 1 when the pixel lies inside the visible screen
// Shared by the renderer and the collision logic so both agree on cell
// numbering.
module m_cell_index #(
  parameter int GRID_W     = m_update_blocks_pkg::GRID_W,
  parameter int CELL_SHIFT = m_update_blocks_pkg::CELL_SHIFT,
  parameter int SCREEN_W   = m_update_blocks_pkg::SCREEN_W,
  parameter int SCREEN_H   = m_update_blocks_pkg::SCREEN_H
) (
  input  logic [7:0] i_x,
  input  logic [6:0] i_y,
  output logic [8:0] o_addr,
  output logic       o_valid
);

  logic [8:0] w_row;
  logic [8:0] w_col;

  // Both operands are widened to 9 bits before the multiply so that even
  // out-of-range coordinates (up to 15*20+31) are represented without loss.
  assign w_row   = 9'(i_y >> CELL_SHIFT);
  assign w_col   = 9'(i_x >> CELL_SHIFT);
  assign o_addr  = (w_row * 9'(GRID_W)) + w_col;
  assign o_valid = (i_x < 8'(SCREEN_W)) && (i_y < 7'(SCREEN_H));

endmodule

// File: rtl/m_update_blocks.sv
// m_update_blocks: fills the blocks RAM or consumes the block under the player.
//   clock     : rising-edge clock
//   resetn    : asynchronous active-low reset
//   enable    : start request, held high until finished is seen
//   init      : 1 = fill every cell, 0 = eat the cell under the player
//   player_x  : player pixel x (0..159 valid)
//   player_y  : player pixel y (0..119 valid)
//   finished  : operation complete, held while enable stays high
//   blk_addr  : blocks RAM address
//   blk_data  : blocks RAM write data
//   blk_wren  : blocks RAM write enable
//   blk_q     : blocks RAM read data (one-cycle read latency)
//   ate       : one-cycle pulse when a block is consumed
//   remaining : number of blocks still present
//   cleared   : remaining is zero and the grid has been filled at least once
module m_update_blocks #(
  parameter int GRID_W     = m_update_blocks_pkg::GRID_W,
  parameter int GRID_H     = m_update_blocks_pkg::GRID_H,
  parameter int CELL_SHIFT = m_update_blocks_pkg::CELL_SHIFT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       init,
  input  logic [7:0] player_x,
  input  logic [6:0] player_y,
  output logic       finished,
  output logic [8:0] blk_addr,
  output logic       blk_data,
  output logic       blk_wren,
  input  logic       blk_q,
  output logic       ate,
  output logic [8:0] remaining,
  output logic       cleared
);

  import m_update_blocks_pkg::*;

  localparam int         CELLS      = GRID_W * GRID_H;
  localparam logic [8:0] LAST_ADDR  = 9'(CELLS - 1);
  localparam logic [8:0] FULL_COUNT = 9'(CELLS);

  state_t     r_state;
  state_t     w_next;

  logic       r_init;
  logic [7:0] r_px;
  logic [6:0] r_py;
  logic [8:0] r_fill_cnt;
  logic [8:0] r_remaining;
  logic       r_cleared;
  logic       r_filled;
  logic       r_finished;

  logic [7:0] w_x;
  logic [6:0] w_y;
  logic [8:0] w_cell;
  logic       w_valid;
  logic [8:0] w_rem_dec;

  logic [8:0] w_addr;
  logic       w_data;
  logic       w_wren;
  logic       w_ate;

  // In IDLE the live coordinates decide whether the eat is in range; after
  // that the latched copy keeps the address stable for the whole operation.
  assign w_x = (r_state == S_IDLE) ? player_x : r_px;
  assign w_y = (r_state == S_IDLE) ? player_y : r_py;

  m_cell_index #(
    .GRID_W     (GRID_W),
    .CELL_SHIFT (CELL_SHIFT),
    .SCREEN_W   (SCREEN_W),
    .SCREEN_H   (SCREEN_H)
  ) u_cell_index (
    .i_x     (w_x),
    .i_y     (w_y),
    .o_addr  (w_cell),
    .o_valid (w_valid)
  );

  assign w_rem_dec = sat_dec(r_remaining);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_addr = '0;
    w_data = 1'b0;
    w_wren = 1'b0;
    w_ate  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          if (init) begin
            w_next = S_FILL;
          end else if (!w_valid) begin
            w_next = S_DONE;
          end else begin
            w_next = S_RD_ADDR;
          end
        end
      end
      S_FILL: begin
        w_addr = r_fill_cnt;
        w_data = 1'b1;
        w_wren = 1'b1;
        if (r_fill_cnt == LAST_ADDR) begin
          w_next = S_DONE;
        end
      end
      S_RD_ADDR: begin
        w_addr = w_cell;
        w_next = S_RD_WAIT;
      end
      // Address is held through the wait so blk_q stays valid in RD_CHK.
      S_RD_WAIT: begin
        w_addr = w_cell;
        w_next = S_RD_CHK;
      end
      S_RD_CHK: begin
        w_addr = w_cell;
        w_next = blk_q ? S_WR_CLR : S_DONE;
      end
      S_WR_CLR: begin
        w_addr = w_cell;
        w_data = 1'b0;
        w_wren = 1'b1;
        w_ate  = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        if (!enable) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_init      <= 1'b0;
      r_px        <= '0;
      r_py        <= '0;
      r_fill_cnt  <= '0;
      r_remaining <= '0;
      r_cleared   <= 1'b0;
      r_filled    <= 1'b0;
      r_finished  <= 1'b0;
    end else begin
      // finished lags DONE by one cycle and drops on the edge that leaves DONE.
      r_finished <= (r_state == S_DONE) && enable;

      if ((r_state == S_IDLE) && enable) begin
        r_init     <= init;
        r_px       <= player_x;
        r_py       <= player_y;
        r_fill_cnt <= '0;
      end

      if (r_state == S_FILL) begin
        if (r_fill_cnt == LAST_ADDR) begin
          r_fill_cnt  <= '0;
          r_remaining <= FULL_COUNT;
          r_cleared   <= 1'b0;
          r_filled    <= r_filled | r_init;
        end else begin
          r_fill_cnt <= r_fill_cnt + 9'd1;
        end
      end

      // cleared is recomputed on the same edge the count changes.
      if (r_state == S_WR_CLR) begin
        r_remaining <= w_rem_dec;
        r_cleared   <= r_filled && (w_rem_dec == '0);
      end
    end
  end

  assign finished  = r_finished;
  assign blk_addr  = w_addr;
  assign blk_data  = w_data;
  assign blk_wren  = w_wren;
  assign ate       = w_ate;
  assign remaining = r_remaining;
  assign cleared   = r_cleared;

endmodule

// File: tb/tb_m_update_blocks.sv
module tb_m_update_blocks;

  logic       clock    = 1'b0;
  logic       resetn   = 1'b1;
  logic       enable   = 1'b0;
  logic       init     = 1'b0;
  logic [7:0] player_x = '0;
  logic [6:0] player_y = '0;
  logic       finished;
  logic [8:0] blk_addr;
  logic       blk_data;
  logic       blk_wren;
  logic       blk_q;
  logic       ate;
  logic [8:0] remaining;
  logic       cleared;

  int checks = 0;
  int errors = 0;

  // Blocks RAM model: synchronous write, one-cycle registered read.
  bit mem [0:511];
  bit q_r = 1'b0;
  assign blk_q = q_r;

  always @(posedge clock) begin
    if (blk_wren) mem[blk_addr] <= blk_data;
    q_r <= mem[blk_addr];
  end

  // Write/ate log sampled mid-cycle.
  logic [9:0] wlog [0:4095];
  int         wr_cnt  = 0;
  int         ate_cnt = 0;
  logic [8:0] rd_addr = '0;

  always @(negedge clock) begin
    if (blk_wren && wr_cnt < 4096) begin
      wlog[wr_cnt] <= {blk_data, blk_addr};
      wr_cnt       <= wr_cnt + 1;
    end
    if (ate) ate_cnt <= ate_cnt + 1;
    if (!blk_wren && blk_addr != 9'd0) rd_addr <= blk_addr;
  end

  m_update_blocks dut (
    .clock     (clock),
    .resetn    (resetn),
    .enable    (enable),
    .init      (init),
    .player_x  (player_x),
    .player_y  (player_y),
    .finished  (finished),
    .blk_addr  (blk_addr),
    .blk_data  (blk_data),
    .blk_wren  (blk_wren),
    .blk_q     (blk_q),
    .ate       (ate),
    .remaining (remaining),
    .cleared   (cleared)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts an operation and returns the number of edges after the sampling
  // edge until finished is seen (-1 on timeout).
  task automatic run_op(input logic i_init, input logic [7:0] x, input logic [6:0] y,
                        output int lat);
    @(negedge clock);
    init     = i_init;
    player_x = x;
    player_y = y;
    enable   = 1'b1;
    @(posedge clock);
    lat = -1;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clock);
      #1;
      if (finished) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic end_op();
    @(negedge clock);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      if (!finished) break;
    end
    check("finished_drop", 32'(finished), 32'd0);
  endtask

  task automatic do_fill(input string tag);
    int lat;
    int s;
    int good;
    s = wr_cnt;
    run_op(1'b1, 8'd0, 7'd0, lat);
    check({tag, "_latency"}, 32'(lat), 32'd301);
    check({tag, "_writes"}, 32'(wr_cnt - s), 32'd300);
    good = 0;
    for (int i = 0; i < 300; i++) begin
      if (wlog[s + i] == {1'b1, 9'(i)}) good++;
    end
    check({tag, "_addr_seq"}, 32'(good), 32'd300);
    check({tag, "_remaining"}, 32'(remaining), 32'd300);
    check({tag, "_cleared"}, 32'(cleared), 32'd0);
    end_op();
  endtask

  initial begin
    int lat;
    int s;
    int a;
    int bad_lat;
    int found;

    // Reset
    #2 resetn = 1'b0;
    #1;
    check("rst_finished", 32'(finished), 32'd0);
    check("rst_wren", 32'(blk_wren), 32'd0);
    check("rst_addr", 32'(blk_addr), 32'd0);
    check("rst_data", 32'(blk_data), 32'd0);
    check("rst_ate", 32'(ate), 32'd0);
    check("rst_remaining", 32'(remaining), 32'd0);
    check("rst_cleared", 32'(cleared), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;

    // Fill
    do_fill("fill1");

    // Eat hit at (37,18) -> cell 44
    s = wr_cnt;
    a = ate_cnt;
    run_op(1'b0, 8'd37, 7'd18, lat);
    check("hit_latency", 32'(lat), 32'd5);
    check("hit_rd_addr", 32'(rd_addr), 32'd44);
    check("hit_writes", 32'(wr_cnt - s), 32'd1);
    check("hit_wr_entry", 32'(wlog[s]), 32'({1'b0, 9'd44}));
    check("hit_ate", 32'(ate_cnt - a), 32'd1);
    check("hit_remaining", 32'(remaining), 32'd299);
    check("hit_cleared", 32'(cleared), 32'd0);
    end_op();

    // Eat miss at the same cell
    s = wr_cnt;
    a = ate_cnt;
    run_op(1'b0, 8'd37, 7'd18, lat);
    check("miss_latency", 32'(lat), 32'd4);
    check("miss_writes", 32'(wr_cnt - s), 32'd0);
    check("miss_ate", 32'(ate_cnt - a), 32'd0);
    check("miss_remaining", 32'(remaining), 32'd299);
    end_op();

    // Out of range x
    s = wr_cnt;
    a = ate_cnt;
    run_op(1'b0, 8'd160, 7'd0, lat);
    check("oorx_latency", 32'(lat), 32'd1);
    check("oorx_writes", 32'(wr_cnt - s), 32'd0);
    check("oorx_ate", 32'(ate_cnt - a), 32'd0);
    check("oorx_remaining", 32'(remaining), 32'd299);
    end_op();

    // Out of range y
    s = wr_cnt;
    run_op(1'b0, 8'd0, 7'd120, lat);
    check("oory_latency", 32'(lat), 32'd1);
    check("oory_writes", 32'(wr_cnt - s), 32'd0);
    check("oory_remaining", 32'(remaining), 32'd299);
    end_op();

    // Clear: refill then eat every cell
    do_fill("fill2");
    a = ate_cnt;
    bad_lat = 0;
    for (int cy = 0; cy < 15; cy++) begin
      for (int cx = 0; cx < 20; cx++) begin
        run_op(1'b0, 8'(cx * 8), 7'(cy * 8), lat);
        if (lat != 5) bad_lat++;
        if (cy * 20 + cx == 298) begin
          check("sweep_rem_one", 32'(remaining), 32'd1);
          check("sweep_not_cleared", 32'(cleared), 32'd0);
        end
        end_op();
      end
    end
    check("sweep_bad_latency", 32'(bad_lat), 32'd0);
    check("sweep_ate", 32'(ate_cnt - a), 32'd300);
    check("sweep_remaining", 32'(remaining), 32'd0);
    check("sweep_cleared", 32'(cleared), 32'd1);

    // 301st eat finds nothing
    a = ate_cnt;
    run_op(1'b0, 8'd0, 7'd0, lat);
    check("extra_latency", 32'(lat), 32'd4);
    check("extra_ate", 32'(ate_cnt - a), 32'd0);
    check("extra_remaining", 32'(remaining), 32'd0);
    check("extra_cleared", 32'(cleared), 32'd1);
    end_op();

    // Reset in the middle of a fill
    @(negedge clock);
    init   = 1'b1;
    enable = 1'b1;
    found  = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clock);
      if (blk_wren && blk_addr == 9'd150) begin
        found = 1;
        break;
      end
    end
    check("midfill_reached", 32'(found), 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("midrst_finished", 32'(finished), 32'd0);
    check("midrst_wren", 32'(blk_wren), 32'd0);
    check("midrst_addr", 32'(blk_addr), 32'd0);
    check("midrst_data", 32'(blk_data), 32'd0);
    check("midrst_ate", 32'(ate), 32'd0);
    check("midrst_remaining", 32'(remaining), 32'd0);
    check("midrst_cleared", 32'(cleared), 32'd0);
    enable = 1'b0;
    init   = 1'b0;
    s = wr_cnt;
    repeat (3) @(posedge clock);
    #1;
    check("midrst_no_writes", 32'(wr_cnt - s), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    do_fill("fill3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
